// File: rtl/signal_conformance_monitor_if.sv
// ============================================================================
// Module      : signal_conformance_monitor_if
// Description : Lamp-code inputs and fault outputs of the signal conformance monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signal_conformance_monitor_if;
  logic [2:0] north_dir;
  logic [2:0] south_dir;
  logic [2:0] east_dir;
  logic [2:0] west_dir;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic       flash_red;
  logic [7:0] fault_count;

  modport master (
    output north_dir, south_dir, east_dir, west_dir, fault_clr,
    input  fault, fault_code, fault_dir, flash_red, fault_count
  );

  modport slave (
    input  north_dir, south_dir, east_dir, west_dir, fault_clr,
    output fault, fault_code, fault_dir, flash_red, fault_count
  );
endinterface

`default_nettype wire

// File: rtl/signal_conformance_monitor.sv
// ============================================================================
// Module      : signal_conformance_monitor
// Description : Independent checker of traffic-signal lamp codes; latches the first
//               violation and drives a flashing-red override. MONITOR_STATS_EN adds
//               a saturating fault-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_conformance_monitor #(
  parameter int MIN_GREEN  = 5,
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_DIV  = 4,
  parameter int CW         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  signal_conformance_monitor_if.slave  mon
);

  localparam logic [2:0]    c_ST_RED    = 3'b100;
  localparam logic [2:0]    c_ST_YELLOW = 3'b010;
  localparam logic [2:0]    c_ST_GREEN  = 3'b001;
  localparam logic [CW-1:0] c_DWELL_MAX = '1;
  localparam logic [CW-1:0] c_MIN_G     = CW'(MIN_GREEN);
  localparam logic [CW-1:0] c_MIN_Y     = CW'(MIN_YELLOW);
  localparam int            c_FW        = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [c_FW-1:0] c_FLASH_LAST = c_FW'(FLASH_DIV - 1);

  logic [2:0] w_code [4];
  logic [3:0] w_legal;
  logic [3:0] w_active;
  logic [3:0] w_bad_trans;
  logic [3:0] w_short_y;
  logic [3:0] w_short_g;
  logic       w_conflict;
  logic       w_viol;
  logic [2:0] w_vcode;
  logic [1:0] w_vdir;

  logic            r_fault;
  logic [2:0]      r_fault_code;
  logic [1:0]      r_fault_dir;
  logic            r_flash;
  logic [c_FW-1:0] r_flash_cnt;

  assign w_code[0] = mon.north_dir;
  assign w_code[1] = mon.south_dir;
  assign w_code[2] = mon.east_dir;
  assign w_code[3] = mon.west_dir;

  // Per-direction last-legal aspect and dwell; illegal codes freeze both.
  generate
    for (genvar d = 0; d < 4; d++) begin : g_dir
      logic [2:0]    r_state;
      logic [CW-1:0] r_dwell;
      logic          w_change;

      assign w_legal[d]  = (w_code[d] == c_ST_RED) || (w_code[d] == c_ST_YELLOW) ||
                           (w_code[d] == c_ST_GREEN);
      assign w_active[d] = (w_code[d] == c_ST_GREEN) || (w_code[d] == c_ST_YELLOW);
      assign w_change    = w_legal[d] && (w_code[d] != r_state);

      assign w_bad_trans[d] = w_change &&
          !(((r_state == c_ST_GREEN)  && (w_code[d] == c_ST_YELLOW)) ||
            ((r_state == c_ST_YELLOW) && (w_code[d] == c_ST_RED))    ||
            ((r_state == c_ST_RED)    && (w_code[d] == c_ST_GREEN)));
      assign w_short_y[d] = w_change && (r_state == c_ST_YELLOW) &&
                            (w_code[d] == c_ST_RED) && (r_dwell < c_MIN_Y);
      assign w_short_g[d] = w_change && (r_state == c_ST_GREEN) &&
                            (w_code[d] == c_ST_YELLOW) && (r_dwell < c_MIN_G);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= c_ST_RED;
          r_dwell <= '0;
        end else if (w_change) begin
          r_state <= w_code[d];
          r_dwell <= CW'(1);
        end else if (w_legal[d] && (r_dwell != c_DWELL_MAX)) begin
          r_dwell <= r_dwell + 1'b1;
        end
      end
    end
  endgenerate

  function automatic logic [1:0] f_first(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // North/south always sort below east/west, so the lowest conflicting
  // direction is always found in the N/S pair.
  assign w_conflict = (w_active[0] | w_active[1]) & (w_active[2] | w_active[3]);

  always_comb begin
    w_vcode = 3'd0;
    w_vdir  = 2'd0;
    if (w_conflict) begin
      w_vcode = 3'd1;
      w_vdir  = w_active[0] ? 2'd0 : 2'd1;
    end else if (|(~w_legal)) begin
      w_vcode = 3'd2;
      w_vdir  = f_first(~w_legal);
    end else if (|w_bad_trans) begin
      w_vcode = 3'd3;
      w_vdir  = f_first(w_bad_trans);
    end else if (|w_short_y) begin
      w_vcode = 3'd4;
      w_vdir  = f_first(w_short_y);
    end else if (|w_short_g) begin
      w_vcode = 3'd5;
      w_vdir  = f_first(w_short_g);
    end
  end

  assign w_viol = (w_vcode != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
      r_fault_dir  <= 2'd0;
      r_flash      <= 1'b0;
      r_flash_cnt  <= '0;
    end else if (!r_fault) begin
      if (w_viol) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_vcode;
        r_fault_dir  <= w_vdir;
        r_flash      <= 1'b1;
        r_flash_cnt  <= '0;
      end
    end else if (mon.fault_clr && !w_viol) begin
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
      r_fault_dir  <= 2'd0;
      r_flash      <= 1'b0;
      r_flash_cnt  <= '0;
    end else if (r_flash_cnt == c_FLASH_LAST) begin
      r_flash     <= ~r_flash;
      r_flash_cnt <= '0;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end

  assign mon.fault      = r_fault;
  assign mon.fault_code = r_fault_code;
  assign mon.fault_dir  = r_fault_dir;
  assign mon.flash_red  = r_flash;

`ifdef MONITOR_STATS_EN
  logic [7:0] r_fault_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_count <= 8'd0;
    end else if (!r_fault && w_viol && (r_fault_count != 8'hFF)) begin
      r_fault_count <= r_fault_count + 8'd1;
    end
  end

  assign mon.fault_count = r_fault_count;
`else
  assign mon.fault_count = 8'd0;
`endif

endmodule

`default_nettype wire
